// File: rtl/shaping_filter_pipe.sv
`default_nettype none
// ------------------------------------------------------------------------
// shaping_filter_pipe : K/L trapezoidal shaper with double integrator,
//                       5-stage pipeline, saturated output.
// Revision: 1.0
// ------------------------------------------------------------------------
module shaping_filter_pipe #(
  parameter int DW    = 12,
  parameter int OW    = 16,
  parameter int ACC_W = 40,
  parameter int KMAX  = 32,
  parameter int LMAX  = 16,
  parameter int SHIFT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DW-1:0]             in_data,
  input  logic                      in_valid,
  input  logic [$clog2(KMAX+1)-1:0] cfg_k,
  input  logic [$clog2(LMAX+1)-1:0] cfg_l,
  input  logic [7:0]                cfg_m1,
  input  logic [7:0]                cfg_m2,
  input  logic                      cfg_load,
  output logic signed [OW-1:0]      out_data,
  output logic                      out_valid,
  output logic                      sat_flag,
  output logic [1:0]                state
);
  localparam int KW  = $clog2(KMAX+1);
  localparam int LW  = $clog2(LMAX+1);
  localparam int KIW = $clog2(KMAX);
  localparam int LIW = $clog2(LMAX);
  localparam int CW  = $clog2(KMAX+LMAX+1);
  localparam logic [KW-1:0] KMAX_C = KW'(KMAX);
  localparam logic [LW-1:0] LMAX_C = LW'(LMAX);
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = {{(ACC_W-OW+1){1'b1}}, {(OW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;
  state_t cur, nxt;

  logic [KW-1:0] k, k_new;
  logic [LW-1:0] l, l_new;
  logic [7:0]    m1, m2;
  logic [CW-1:0] cnt, kl;
  logic          accept;

  logic [DW-1:0]             xl [KMAX];
  logic signed [ACC_W-1:0]   dl [LMAX];
  logic [KIW-1:0]            kidx;
  logic [LIW-1:0]            lidx;
  logic signed [ACC_W-1:0]   kx, m1x, m2x, xin;
  logic signed [ACC_W-1:0]   dk, d1, e, mp, p, q, s, sh;
  logic [4:0]                vt, rt;
  logic signed [OW-1:0]      y;
  logic                      clip;

  assign accept = in_valid & ~cfg_load;
  assign kl     = CW'(k) + CW'(l);
  assign kidx   = KIW'(k - 1'b1);
  assign lidx   = LIW'(l - 1'b1);
  assign kx     = ACC_W'(k);
  assign m1x    = ACC_W'(m1);
  assign m2x    = ACC_W'(m2);
  assign xin    = ACC_W'(in_data);
  assign state  = cur;

  always_comb begin
    k_new = cfg_k;
    l_new = cfg_l;
    if (cfg_k == '0)         k_new = KW'(1);
    else if (cfg_k > KMAX_C) k_new = KMAX_C;
    if (cfg_l == '0)         l_new = LW'(1);
    else if (cfg_l > LMAX_C) l_new = LMAX_C;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    if (cfg_load) begin
      nxt = IDLE;
    end else if (in_valid) begin
      case (cur)
        IDLE:    nxt = FILL;
        FILL:    if (cnt + CW'(1) == kl) nxt = RUN;
        default: nxt = cur;
      endcase
    end
  end

  always_comb begin
    sh   = s >>> SHIFT;
    y    = sh[OW-1:0];
    clip = 1'b0;
    if (sh > SAT_HI) begin
      y    = {1'b0, {(OW-1){1'b1}}};
      clip = 1'b1;
    end else if (sh < SAT_LO) begin
      y    = {1'b1, {(OW-1){1'b0}}};
      clip = 1'b1;
    end
  end

  // Stage operand registers are gated by their tags, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      dk <= xin - ACC_W'(xl[kidx]);
      d1 <= xin - ACC_W'(xl[0]);
    end
    if (vt[0]) e  <= dk - kx * dl[lidx];
    if (vt[2]) mp <= m1x * p;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k <= KW'(4); l <= LW'(2); m1 <= 8'd16; m2 <= 8'd1;
      for (int i = 0; i < KMAX; i++) xl[i] <= '0;
      for (int i = 0; i < LMAX; i++) dl[i] <= '0;
      p <= '0; q <= '0; s <= '0; vt <= '0; rt <= '0; cnt <= '0;
      out_data <= '0; out_valid <= 1'b0; sat_flag <= 1'b0;
    end else if (cfg_load) begin
      k <= k_new; l <= l_new; m1 <= cfg_m1; m2 <= cfg_m2;
      for (int i = 0; i < KMAX; i++) xl[i] <= '0;
      for (int i = 0; i < LMAX; i++) dl[i] <= '0;
      p <= '0; q <= '0; s <= '0; vt <= '0; rt <= '0; cnt <= '0;
      out_valid <= 1'b0; sat_flag <= 1'b0;
    end else begin
      vt <= {vt[3:0], accept};
      rt <= {rt[3:0], accept && (cur == RUN)};
      if (accept) begin
        for (int i = KMAX-1; i > 0; i--) xl[i] <= xl[i-1];
        xl[0] <= in_data;
        if (cur != RUN) cnt <= cnt + CW'(1);
      end
      if (vt[0]) begin
        for (int i = LMAX-1; i > 0; i--) dl[i] <= dl[i-1];
        dl[0] <= d1;
      end
      if (vt[1]) p <= p + e;
      if (vt[2]) q <= q + m2x * p;
      if (vt[3]) s <= s + q + mp;
      out_valid <= vt[4] & rt[4];
      if (vt[4] & rt[4]) begin
        out_data <= y;
        if (clip) sat_flag <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shaping_filter_pipe.sv
`default_nettype none
// Bench for shaping_filter_pipe: random stimulus checked against a
// sample-level model of the filter equations and FSM rules.
module tb_shaping_filter_pipe;
  logic clk = 1'b0;
  logic reset;
  logic [11:0] in_data;
  logic in_valid, cfg_load;
  logic [5:0] cfg_k;
  logic [4:0] cfg_l;
  logic [7:0] cfg_m1, cfg_m2;
  logic signed [15:0] out_data;
  logic out_valid, sat_flag;
  logic [1:0] state;

  shaping_filter_pipe dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m1(cfg_m1), .cfg_m2(cfg_m2),
    .cfg_load(cfg_load), .out_data(out_data), .out_valid(out_valid),
    .sat_flag(sat_flag), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model state
  int     xs[$];
  int     ds[$];
  longint mp_, mq, ms;
  int     mk, ml, mm1, mm2;
  bit     msat;
  bit     slot_v[8];
  bit     slot_c[8];
  int     slot_d[8];
  int     cyc = 0;
  int     run_accepts;
  int     ref_seq[$];
  logic [19:0] exp_vec;

  function automatic longint wrap40(input longint v);
    longint r = v & 64'h0000_00FF_FFFF_FFFF;
    if (r[39]) r = r - 64'sh0000_0100_0000_0000;
    return r;
  endfunction

  function automatic int exp_state();
    if (xs.size() == 0) return 0;
    if (xs.size() < mk + ml) return 1;
    return 2;
  endfunction

  function automatic logic [19:0] obs_vec();
    return {out_valid, out_valid ? out_data : 16'h0, state, sat_flag};
  endfunction

  task automatic flush();
    xs.delete(); ds.delete();
    mp_ = 0; mq = 0; ms = 0; msat = 0; run_accepts = 0;
    for (int i = 0; i < 8; i++) slot_v[i] = 0;
  endtask

  task automatic model_reset();
    flush();
    mk = 4; ml = 2; mm1 = 16; mm2 = 1;
  endtask

  task automatic model_accept(input int d);
    int n = xs.size();
    longint xk, xp, dlv, dkv, d1v, yv;
    bit c = 0;
    xk  = (n >= mk) ? xs[n-mk] : 0;
    xp  = (n >= 1)  ? xs[n-1]  : 0;
    dlv = (n >= ml) ? ds[n-ml] : 0;
    dkv = d - xk;
    d1v = d - xp;
    mp_ = wrap40(mp_ + dkv - mk * dlv);
    mq  = wrap40(mq + mm2 * mp_);
    ms  = wrap40(ms + mq + mm1 * mp_);
    yv  = ms >>> 8;
    if (yv > 32767) begin yv = 32767; c = 1; end
    else if (yv < -32768) begin yv = -32768; c = 1; end
    xs.push_back(d);
    ds.push_back(int'(d1v));
    if (n >= mk + ml) begin
      slot_v[(cyc+5)%8] = 1;
      slot_d[(cyc+5)%8] = int'(yv);
      slot_c[(cyc+5)%8] = c;
      run_accepts++;
    end
  endtask

  // One clock of stimulus; leaves the expected output vector for this edge in exp_vec.
  task automatic drive(input bit v, input int d, input bit ld);
    int idx;
    bit ev, ec;
    int ed;
    in_valid = v; in_data = 12'(d); cfg_load = ld;
    @(posedge clk); #1;
    cyc++;
    idx = cyc % 8;
    ev = slot_v[idx]; ed = slot_d[idx]; ec = slot_c[idx];
    slot_v[idx] = 0;
    if (ld) begin
      flush();
      ev = 0;
      mk  = (cfg_k == 0) ? 1 : (cfg_k > 32) ? 32 : int'(cfg_k);
      ml  = (cfg_l == 0) ? 1 : (cfg_l > 16) ? 16 : int'(cfg_l);
      mm1 = int'(cfg_m1); mm2 = int'(cfg_m2);
    end else begin
      if (ev && ec) msat = 1;
      if (v) model_accept(d);
    end
    exp_vec = {ev, ev ? 16'(ed) : 16'h0, 2'(exp_state()), msat};
    in_valid = 0; cfg_load = 0;
  endtask

  task automatic pulse_reset();
    reset = 0; #2; reset = 1;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 0; in_valid = 0; in_data = 0; cfg_load = 0;
    cfg_k = 6'd4; cfg_l = 5'd2; cfg_m1 = 8'd16; cfg_m2 = 8'd1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_data, sat_flag, state} !== 20'h0) begin
      errors++; $display("FAIL reset_state got %h want 0", {out_valid, out_data, sat_flag, state});
    end
    @(posedge clk); #1;
    reset = 1;
    model_reset();
  endtask

  task automatic test_zero_fill();
    int acc7 = -1, first_ov = -1;
    for (int i = 0; i < 100; i++) begin
      drive(1, 0, 0);
      if (i == 6) acc7 = cyc;
      if (out_valid && first_ov < 0) first_ov = cyc;
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++; $display("FAIL zero_fill cyc %0d got %h want %h", cyc, obs_vec(), exp_vec);
      end
      if (i == 0) begin
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL zero_fill_fill got %0d want 1", state); end
      end
      if (i == 5) begin
        checks++;
        if (state !== 2'd2) begin errors++; $display("FAIL zero_fill_run got %0d want 2", state); end
      end
    end
    checks++;
    if (first_ov != acc7 + 5) begin
      errors++; $display("FAIL zero_fill_latency got %0d want %0d", first_ov, acc7 + 5);
    end
  endtask

  task automatic test_step();
    pulse_reset();
    for (int i = 0; i < 218; i++) begin
      drive(i < 210, (i < 10) ? 0 : 1000, 0);
      if (exp_vec[19]) ref_seq.push_back(int'($signed(exp_vec[18:3])));
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++; $display("FAIL step cyc %0d got %h want %h", cyc, obs_vec(), exp_vec);
      end
    end
  endtask

  task automatic test_gaps();
    int obs[$];
    int bad = 0;
    pulse_reset();
    for (int i = 0; i < 218; i++) begin
      int gap = (i < 210) ? int'($urandom_range(0, 2)) : 0;
      for (int g = 0; g <= gap; g++) begin
        if (g < gap) drive(0, int'($urandom_range(0, 4095)), 0);
        else         drive(i < 210, (i < 10) ? 0 : 1000, 0);
        if (out_valid) obs.push_back(int'(out_data));
        checks++;
        if (obs_vec() !== exp_vec) begin
          errors++; $display("FAIL gaps cyc %0d got %h want %h", cyc, obs_vec(), exp_vec);
        end
      end
    end
    checks++;
    if (obs.size() != run_accepts || obs.size() != ref_seq.size()) begin
      errors++; $display("FAIL gaps_count got %0d want %0d", obs.size(), ref_seq.size());
    end
    for (int i = 0; i < obs.size() && i < ref_seq.size(); i++)
      if (obs[i] != ref_seq[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL gaps_sequence got %0d differing outputs want 0", bad);
    end
  endtask

  task automatic test_saturation();
    cfg_k = 6'd32; cfg_l = 5'd16; cfg_m1 = 8'd255; cfg_m2 = 8'd255;
    drive(0, 0, 1);
    for (int i = 0; i < 150; i++) begin
      drive(1, 4095, 0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++; $display("FAIL saturation cyc %0d got %h want %h", cyc, obs_vec(), exp_vec);
      end
    end
    checks++;
    if (sat_flag !== 1'b1) begin errors++; $display("FAIL saturation_flag got %0b want 1", sat_flag); end
  endtask

  task automatic test_cfg_load();
    pulse_reset();
    for (int i = 0; i < 20; i++) drive(1, int'($urandom_range(0, 4095)), 0);
    cfg_k = 6'd8; cfg_l = 5'd4;
    cfg_m1 = 8'($urandom_range(0, 255)); cfg_m2 = 8'($urandom_range(0, 255));
    drive(1, int'($urandom_range(0, 4095)), 1);
    checks++;
    if (state !== 2'd0 || sat_flag !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL cfg_load_flush got st=%0d sat=%0b ov=%0b want 0 0 0", state, sat_flag, out_valid);
    end
    for (int i = 0; i < 28; i++) begin
      drive(i < 22, int'($urandom_range(0, 4095)), 0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++; $display("FAIL cfg_load cyc %0d got %h want %h", cyc, obs_vec(), exp_vec);
      end
      if (i == 10 || i == 11) begin
        checks++;
        if (state !== ((i == 11) ? 2'd2 : 2'd1)) begin
          errors++; $display("FAIL cfg_load_run sample %0d got %0d", i + 1, state);
        end
      end
    end
    cfg_k = 6'd0; cfg_l = 5'd31;
    drive(0, 0, 1);
    for (int i = 0; i < 25; i++) begin
      drive(1, int'($urandom_range(0, 4095)), 0);
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++; $display("FAIL cfg_clamp cyc %0d got %h want %h", cyc, obs_vec(), exp_vec);
      end
      if (i == 15 || i == 16) begin
        checks++;
        if (state !== ((i == 16) ? 2'd2 : 2'd1)) begin
          errors++; $display("FAIL cfg_clamp_run sample %0d got %0d", i + 1, state);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int acc7 = -1, first_ov = -1;
    for (int i = 0; i < 30; i++) drive(1, int'($urandom_range(0, 4095)), 0);
    #3 reset = 0;
    #1;
    checks++;
    if ({out_valid, out_data, sat_flag, state} !== 20'h0) begin
      errors++; $display("FAIL async_reset got %h want 0", {out_valid, out_data, sat_flag, state});
    end
    #2 reset = 1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1, int'($urandom_range(0, 4095)), 0);
      if (i == 6) acc7 = cyc;
      if (out_valid && first_ov < 0) first_ov = cyc;
      checks++;
      if (obs_vec() !== exp_vec) begin
        errors++; $display("FAIL async_after cyc %0d got %h want %h", cyc, obs_vec(), exp_vec);
      end
    end
    checks++;
    if (first_ov != acc7 + 5) begin
      errors++; $display("FAIL async_latency got %0d want %0d", first_ov, acc7 + 5);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      cfg_k = 6'($urandom_range(0, 63)); cfg_l = 5'($urandom_range(0, 31));
      cfg_m1 = 8'($urandom_range(0, 255)); cfg_m2 = 8'($urandom_range(0, 255));
      drive(1, 0, 1);
      for (int i = 0; i < 150; i++) begin
        drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 4095)), $urandom_range(0, 99) == 0);
        checks++;
        if (obs_vec() !== exp_vec) begin
          errors++; $display("FAIL random cyc %0d got %h want %h", cyc, obs_vec(), exp_vec);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_fill();
    test_step();
    test_gaps();
    test_saturation();
    test_cfg_load();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
